// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//
// Sequences a 2-way, 64-set, 2-word-line data cache between the MEM stage
// and the SRAM controller. The cache policy is read-allocate, write-through
// and write-no-allocate. A write that hits invalidates the matching line.
// The pipeline is stalled through `ready` while an SRAM transaction is
// outstanding.
//
// Optional feature (macro CACHE_STATS_EN): adds saturating hit/miss counters
// on the hit_cnt / miss_cnt outputs. Without the macro, those ports do not
// exist.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   address, wdata     CPU byte address (word aligned) and store data
//   mem_r_en, mem_w_en CPU load/store requests, held until ready
//   rdata, ready       load data and request-complete / no-stall
//   cache_*            lookup, fill, invalidate and hit interface to the cache
//   sram_*             line read / word write interface to the SRAM controller
//   hit_cnt, miss_cnt  statistics counters (CACHE_STATS_EN only)
// ---------------------------------------------------------------------------
module cache_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          CADDR_W   = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [CADDR_W-1:0] cache_addr,
    output logic               cache_r_en,
    output logic               cache_fill,
    output logic [63:0]        cache_line,
    output logic               cache_inval,
    input  logic               cache_hit,
    input  logic [31:0]        cache_rdata,
    output logic [CADDR_W-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    output logic               sram_r_en,
    output logic               sram_w_en,
    input  logic               sram_ready,
    input  logic [63:0]        sram_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        FILL    = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [63:0]  line_q, line_d;
    logic [CADDR_W-1:0] rel_addr;

    // 32-bit subtraction, truncated to the cache/SRAM address width.
    assign rel_addr   = CADDR_W'(address - BASE_ADDR);
    assign cache_addr = rel_addr;
    assign cache_line = line_q;
    assign sram_wdata = wdata;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        ready       = 1'b0;
        rdata       = 32'd0;
        cache_r_en  = 1'b0;
        cache_fill  = 1'b0;
        cache_inval = 1'b0;
        sram_r_en   = 1'b0;
        sram_w_en   = 1'b0;
        sram_addr   = rel_addr;

        // While reset is held, outputs sit at their idle values regardless
        // of the CPU requests so nothing downstream sees a spurious strobe.
        if (!rst) begin
            ready = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cache_r_en = mem_r_en;
                    if (mem_w_en) begin
                        // Write wins over a simultaneous read.
                        cache_inval = cache_hit;
                        state_d     = WR;
                    end else if (mem_r_en) begin
                        if (cache_hit) begin
                            ready = 1'b1;
                            rdata = cache_rdata;
                        end else begin
                            state_d = RD_MISS;
                        end
                    end else begin
                        ready = 1'b1;
                    end
                end
                RD_MISS: begin
                    sram_r_en = 1'b1;
                    // Line reads are always aligned to the two-word line.
                    sram_addr = {rel_addr[CADDR_W-1:3], 1'b0, rel_addr[1:0]};
                    if (sram_ready) begin
                        line_d  = sram_rdata;
                        state_d = FILL;
                    end
                end
                FILL: begin
                    cache_fill = 1'b1;
                    ready      = 1'b1;
                    rdata      = address[2] ? line_q[63:32] : line_q[31:0];
                    state_d    = IDLE;
                end
                WR: begin
                    sram_w_en = 1'b1;
                    if (sram_ready) begin
                        ready   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            line_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        idle_rd;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Only reads that are not overridden by a simultaneous write count.
    assign idle_rd = (state_q == IDLE) && mem_r_en && !mem_w_en;

    always_comb begin
        hit_cnt_d  = sat_inc(hit_cnt_q, idle_rd && cache_hit);
        miss_cnt_d = sat_inc(miss_cnt_q, idle_rd && !cache_hit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

    localparam int CADDR_W = 19;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        address;
    logic [31:0]        wdata;
    logic               mem_r_en;
    logic               mem_w_en;
    logic [31:0]        rdata;
    logic               ready;
    logic [CADDR_W-1:0] cache_addr;
    logic               cache_r_en;
    logic               cache_fill;
    logic [63:0]        cache_line;
    logic               cache_inval;
    logic               cache_hit;
    logic [31:0]        cache_rdata;
    logic [CADDR_W-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic               sram_r_en;
    logic               sram_w_en;
    logic               sram_ready;
    logic [63:0]        sram_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    cache_controller #(.BASE_ADDR(32'd1024), .CADDR_W(CADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .wdata       (wdata),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .rdata       (rdata),
        .ready       (ready),
        .cache_addr  (cache_addr),
        .cache_r_en  (cache_r_en),
        .cache_fill  (cache_fill),
        .cache_line  (cache_line),
        .cache_inval (cache_inval),
        .cache_hit   (cache_hit),
        .cache_rdata (cache_rdata),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_r_en   (sram_r_en),
        .sram_w_en   (sram_w_en),
        .sram_ready  (sram_ready),
        .sram_rdata  (sram_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read-miss sequence; the SRAM answers on the lat-th RD_MISS cycle.
    task automatic read_miss(input logic [31:0] addr, input logic [63:0] line, input int lat);
        logic [31:0] rel;
        logic [31:0] exp_word;
        rel      = addr - 32'd1024;
        exp_word = addr[2] ? line[63:32] : line[31:0];
        address  = addr;
        mem_r_en = 1'b1;
        mem_w_en = 1'b0;
        cache_hit = 1'b0;
        #1;
        chk("miss_idle_ready", ready, 0);
        chk("miss_idle_r_en", cache_r_en, 1);
        tick();
        for (int i = 0; i < lat; i++) begin
            sram_ready = (i == lat - 1);
            sram_rdata = (i == lat - 1) ? line : 64'h0;
            #1;
            chk("miss_sram_r_en", sram_r_en, 1);
            chk("miss_sram_addr", sram_addr, {rel[CADDR_W-1:3], 3'b000});
            chk("miss_ready", ready, 0);
            chk("miss_cache_r_en", cache_r_en, 0);
            tick();
        end
        sram_ready = 1'b0;
        sram_rdata = 64'h0;
        #1;
        chk("fill_strobe", cache_fill, 1);
        chk("fill_line", cache_line, line);
        chk("fill_rdata", rdata, exp_word);
        chk("fill_ready", ready, 1);
        chk("fill_sram_r_en", sram_r_en, 0);
        tick();
        mem_r_en = 1'b0;
    endtask

    task automatic read_hit(input logic [31:0] addr, input logic [31:0] data);
        address     = addr;
        mem_r_en    = 1'b1;
        mem_w_en    = 1'b0;
        cache_hit   = 1'b1;
        cache_rdata = data;
        #1;
        chk("hit_ready", ready, 1);
        chk("hit_rdata", rdata, data);
        chk("hit_cache_r_en", cache_r_en, 1);
        chk("hit_cache_addr", cache_addr, addr - 32'd1024);
        chk("hit_sram_r_en", sram_r_en, 0);
        tick();
        mem_r_en  = 1'b0;
        cache_hit = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        address     = 32'd1024;
        wdata       = 32'd0;
        mem_r_en    = 1'b1;
        mem_w_en    = 1'b0;
        cache_hit   = 1'b0;
        cache_rdata = 32'hDEAD_BEEF;
        sram_ready  = 1'b0;
        sram_rdata  = 64'h0;

        // Reset with a pending load: everything idle, ready high.
        #2;
        chk("rst_ready", ready, 1);
        chk("rst_rdata", rdata, 0);
        chk("rst_cache_r_en", cache_r_en, 0);
        chk("rst_sram_r_en", sram_r_en, 0);
        chk("rst_sram_w_en", sram_w_en, 0);
        chk("rst_fill", cache_fill, 0);
        chk("rst_inval", cache_inval, 0);
        chk("rst_line", cache_line, 0);
        tick();
        tick();
        mem_r_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("idle_ready", ready, 1);
        chk("idle_rdata", rdata, 0);
        tick();

        // Read miss at 1024+8 with 4-cycle SRAM, then a hit to the same line.
        read_miss(32'd1032, 64'hBBBB_BBBB_AAAA_AAAA, 4);
        read_hit(32'd1036, 32'hBBBB_BBBB);
        chk("after_hit_sram_r_en", sram_r_en, 0);

        // Upper-word miss with single-cycle SRAM latency.
        read_miss(32'd1044, 64'h2222_2222_1111_1111, 1);

        // Write hit: invalidate pulse, SRAM write held until sram_ready.
        address   = 32'd1040;
        wdata     = 32'h0000_1234;
        mem_w_en  = 1'b1;
        cache_hit = 1'b1;
        #1;
        chk("wr_inval", cache_inval, 1);
        chk("wr_idle_ready", ready, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            sram_ready = (i == 2);
            #1;
            chk("wr_sram_w_en", sram_w_en, 1);
            chk("wr_sram_addr", sram_addr, 16);
            chk("wr_sram_wdata", sram_wdata, 32'h0000_1234);
            chk("wr_inval_once", cache_inval, 0);
            chk("wr_ready", ready, (i == 2) ? 1 : 0);
            tick();
        end
        sram_ready = 1'b0;
        mem_w_en   = 1'b0;
        cache_hit  = 1'b0;
        #1;
        chk("wr_done_w_en", sram_w_en, 0);
        chk("wr_done_ready", ready, 1);
        tick();

        // Simultaneous read and write: the write path wins.
        address  = 32'd1048;
        wdata    = 32'h5555_6666;
        mem_r_en = 1'b1;
        mem_w_en = 1'b1;
        #1;
        chk("rw_ready", ready, 0);
        chk("rw_inval", cache_inval, 0);
        tick();
        sram_ready = 1'b1;
        #1;
        chk("rw_sram_w_en", sram_w_en, 1);
        chk("rw_sram_r_en", sram_r_en, 0);
        chk("rw_fill", cache_fill, 0);
        chk("rw_ready_done", ready, 1);
        tick();
        sram_ready = 1'b0;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        #1;
        chk("rw_after_fill", cache_fill, 0);
        chk("rw_after_w_en", sram_w_en, 0);
        tick();

        // Reset two cycles into a read miss.
        address  = 32'd1048;
        mem_r_en = 1'b1;
        tick();
        tick();
        #1;
        chk("rmm_pre_r_en", sram_r_en, 1);
        rst = 1'b0;
        #1;
        chk("rmm_r_en_drop", sram_r_en, 0);
        chk("rmm_ready", ready, 1);
        tick();
        rst        = 1'b1;
        mem_r_en   = 1'b0;
        sram_ready = 1'b1;
        sram_rdata = 64'h9999_9999_8888_8888;
        #1;
        chk("rmm_ignored_r_en", sram_r_en, 0);
        tick();
        sram_ready = 1'b0;
        sram_rdata = 64'h0;
        #1;
        chk("rmm_no_fill", cache_fill, 0);
        chk("rmm_line_clear", cache_line, 0);
        chk("rmm_idle_ready", ready, 1);
        tick();

        // Three hits and two misses from a freshly reset controller.
        read_hit(32'd1024, 32'h0000_0001);
        read_miss(32'd1056, 64'h4444_4444_3333_3333, 2);
        read_hit(32'd1028, 32'h0000_0002);
        read_miss(32'd1068, 64'h6666_6666_5555_5555, 3);
        read_hit(32'd1068, 32'h6666_6666);
`ifdef CACHE_STATS_EN
        chk("stats_hit_cnt", hit_cnt, 3);
        chk("stats_miss_cnt", miss_cnt, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequences the 2-way, 64-set, 2-word-line data cache between the MEM stage and the SRAM controller.
- Policy: read-allocate, write-through, write-no-allocate; a write that hits invalidates the matching line.
- Stalls the pipeline through `ready` while an SRAM transaction is outstanding.

Parameters:
- BASE_ADDR, 1024, byte address subtracted from the CPU address before indexing the cache and SRAM.
- CADDR_W, 19, width of the cache/SRAM-relative byte address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  in  32  CPU byte address, word aligned.
- wdata  in  32  CPU store data.
- mem_r_en  in  1  CPU load request, held until ready.
- mem_w_en  in  1  CPU store request, held until ready.
- rdata  out  32  load data, valid when ready & mem_r_en.
- ready  out  1  request complete / no stall.
- cache_addr  out  CADDR_W  (address - BASE_ADDR)[CADDR_W-1:0].
- cache_r_en  out  1  lookup strobe; updates LRU on a hit.
- cache_fill  out  1  one-cycle line write of cache_line.
- cache_line  out  64  {word1, word0} line captured from SRAM.
- cache_inval  out  1  one-cycle invalidate of the hitting way.
- cache_hit  in  1  combinational hit from the cache.
- cache_rdata  in  32  combinational hit data.
- sram_addr  out  CADDR_W  relative address to SRAM; bit 2 forced to 0 on line reads.
- sram_wdata  out  32  store data.
- sram_r_en  out  1  line read request, level, held until sram_ready.
- sram_w_en  out  1  word write request, level, held until sram_ready.
- sram_ready  in  1  one-cycle completion pulse.
- sram_rdata  in  64  line data, valid with sram_ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the line register clears to 0.
  - All strobes are 0; rdata=0; ready=1.
- States: IDLE, RD_MISS, FILL, WR.
- IDLE:
  - cache_r_en = mem_r_en.
  - mem_r_en & cache_hit: ready=1 and rdata=cache_rdata in the same cycle (0-cycle latency); stay in IDLE.
  - mem_r_en & ~cache_hit: ready=0; next state RD_MISS.
  - mem_w_en: ready=0; cache_inval = cache_hit (1 cycle); next state WR.
  - If mem_r_en and mem_w_en are both high, the write wins; the read is ignored.
  - No request: ready=1, rdata=0.
- RD_MISS:
  - sram_r_en=1, sram_addr = line-aligned address, ready=0.
  - On sram_ready: capture sram_rdata into the line register; next state FILL.
- FILL:
  - cache_fill=1, cache_line = line register.
  - ready=1; rdata = address[2] ? line[63:32] : line[31:0].
  - Next state IDLE unconditionally.
  - Total read-miss latency is SRAM latency + 1 cycle.
- WR:
  - sram_w_en=1, sram_wdata=wdata, sram_addr = word address, ready=0.
  - On sram_ready: ready=1 in the same cycle; next state IDLE.
- Address arithmetic: 32-bit subtraction, low CADDR_W bits kept, no range check.
- sram_ready outside RD_MISS/WR is ignored.
- The cache is never accessed while an SRAM transaction is outstanding.
- Requests dropped mid-transaction: the SRAM transaction completes anyway, because the controller has already committed.
  - A dropped read still fills the cache.
  - A dropped write still writes SRAM.
- Reset mid-transaction: return to IDLE immediately; the pending SRAM request deasserts the same instant.
- Back-to-back: a new request may be presented the cycle after ready=1 and is evaluated from IDLE.
  - A read to the same line right after FILL hits.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
  - hit_cnt +1 on each IDLE read hit.
  - miss_cnt +1 on each IDLE→RD_MISS transition.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset: rst=0 with mem_r_en=1 → ready=1, all sram/cache strobes 0, rdata=0.
- Read miss:
  - Stimulus: load 1024+8, cache_hit=0, SRAM returns 64'hBBBB_BBBB_AAAA_AAAA after 4 cycles.
  - Response: sram_r_en high 4 cycles with sram_addr=8; FILL cycle has cache_fill=1 and rdata=32'hAAAA_AAAA.
  - A repeat load 1024+12 with cache_hit=1 → ready the same cycle.
- Write hit:
  - Stimulus: store 32'h1234 to 1024+16 with cache_hit=1.
  - Response: cache_inval pulses 1 cycle; sram_w_en holds until sram_ready; ready=1 on that cycle only.
- Simultaneous r/w: mem_r_en=mem_w_en=1 → WR path taken, cache_fill never asserted.
- Reset mid-miss: rst=0 two cycles into RD_MISS → sram_r_en drops immediately; state IDLE; a later sram_ready pulse is ignored.
- Stats (CACHE_STATS_EN): 3 hits and 2 misses → hit_cnt=3, miss_cnt=2.
